fetch_stage: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the synchronous-read instruction memory.
- Owns the PC and drives the memory read address. Pairs each returned instruction word with its PC.
- Delivers the pair to decode over a valid/ready handshake.
- Absorbs the memory's one-cycle read latency, decode stalls, branch/jump redirects and a fetch-enable pause.

---
 rtl/fetch_stage.sv | 155 +++++++++++++++
 tb/tb_fetch_stage.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end.
// Owns the PC, drives the synchronous-read instruction memory address, and pairs
// each returned word with its PC for decode over a valid/ready handshake.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN;
// without it, redirect targets are forced word-aligned and out_misalign is 0.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_misalign,
  output logic [31:0] fetch_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_TRAP = 2'd2;

  // pc_q holds the address whose word is on imem_rd_data while running,
  // or the next address to fetch while idle.
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  st_q, st_d;

  // Redirect target after alignment handling, and the state a redirect lands in.
  logic [31:0] tgt_pc;
  logic [1:0]  tgt_st;
  logic [31:0] pc_inc;

  assign pc_inc = pc_q + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Set once the trap NOP has been handed to decode so it is delivered only once.
  logic trap_acc_q, trap_acc_d;
  logic tgt_mis;

  assign tgt_pc = redirect_pc;
  assign tgt_mis = |redirect_pc[1:0];
  assign tgt_st = tgt_mis ? ST_TRAP : (fetch_en ? ST_RUN : ST_IDLE);
`else
  // Low address bits are simply dropped: the target is always word-aligned.
  assign tgt_pc = redirect_pc & 32'hFFFF_FFFC;
  assign tgt_st = fetch_en ? ST_RUN : ST_IDLE;
`endif

  assign out_pc      = pc_q;
  assign fetch_count = cnt_q;

  // Next-state, memory address and decode-side outputs; redirect beats stall beats advance.
  always_comb begin
    pc_d         = pc_q;
    st_d         = st_q;
    cnt_d        = cnt_q;
    imem_addr    = pc_q;
    out_valid    = 1'b0;
    out_misalign = 1'b0;
    out_inst     = imem_rd_data;
`ifdef FETCH_MISALIGN_TRAP_EN
    trap_acc_d   = trap_acc_q;
`endif
    case (st_q)
      ST_IDLE: begin
        if (redirect_valid) begin
          imem_addr = tgt_pc;
          pc_d      = tgt_pc;
          st_d      = tgt_st;
        end else if (fetch_en) begin
          // Word for pc_q arrives next cycle; that is the single restart bubble.
          st_d = ST_RUN;
        end
      end
      ST_RUN: begin
        out_valid = ~redirect_valid;
        if (redirect_valid) begin
          // Current word is squashed and the target fetch starts immediately.
          imem_addr = tgt_pc;
          pc_d      = tgt_pc;
          st_d      = tgt_st;
        end else if (out_ready) begin
          imem_addr = pc_inc;
          pc_d      = pc_inc;
          cnt_d     = cnt_q + 32'd1;
          st_d      = fetch_en ? ST_RUN : ST_IDLE;
        end
        // Stall: re-presenting pc_q keeps imem_rd_data stable.
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      ST_TRAP: begin
        out_misalign = 1'b1;
        out_inst     = NOP_INST;
        out_valid    = ~redirect_valid & ~trap_acc_q;
        if (redirect_valid) begin
          imem_addr = tgt_pc;
          pc_d      = tgt_pc;
          st_d      = tgt_st;
        end else if (out_ready && !trap_acc_q) begin
          cnt_d      = cnt_q + 32'd1;
          trap_acc_d = 1'b1;
        end
      end
`endif
      default: begin
        st_d = ST_IDLE;
      end
    endcase
`ifdef FETCH_MISALIGN_TRAP_EN
    // Any redirect (including one that re-arms the trap) clears the delivered flag.
    if (redirect_valid) begin
      trap_acc_d = 1'b0;
    end
`endif
    // Reset dominates everything visible to memory and decode.
    if (rst) begin
      imem_addr    = RESET_PC;
      out_valid    = 1'b0;
      out_misalign = 1'b0;
    end
  end

  // PC, state and delivered-instruction counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      st_q  <= ST_IDLE;
      cnt_q <= 32'd0;
    end else begin
      pc_q  <= pc_d;
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Trap-delivered flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      trap_acc_q <= 1'b0;
    end else begin
      trap_acc_q <= trap_acc_d;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with a synchronous-read memory model.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam int MACRO_ON = 1;
`else
  localparam int MACRO_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_misalign;
  logic [31:0] fetch_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk),
    .rst(rst),
    .fetch_en(fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_addr(imem_addr),
    .imem_rd_data(imem_rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_inst(out_inst),
    .out_misalign(out_misalign),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Memory content is a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {20'hC0DE0, a[11:2], 2'b00} ^ {a[31:24], 24'h0};
  endfunction

  // Synchronous-read instruction memory.
  always @(posedge clk) imem_rd_data <= mem_word({imem_addr[31:2], 2'b00});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push_pc(input logic [31:0] pc);
    exp_t e;
    e.pc = pc;
    e.inst = mem_word(pc);
    e.mis = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_trap(input logic [31:0] pc);
    exp_t e;
    e.pc = pc;
    e.inst = 32'h0000_0013;
    e.mis = 1'b1;
    sb.push_back(e);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard: each handshake pops and compares one expected delivery.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("sb_pc", out_pc, e.pc);
        check("sb_inst", out_inst, e.inst);
        check("sb_mis", 32'(out_misalign), 32'(e.mis));
        $display("deliver pc=%h inst=%h mis=%0d cnt=%0d", out_pc, out_inst, out_misalign, fetch_count);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    fetch_en = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    out_ready = 1'b1;
    nxt();
    nxt();
    smp();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_mis", 32'(out_misalign), 32'd0);
    check("rst_cnt", fetch_count, 32'd0);
    nxt();

    // Reset release: one bubble, then back-to-back delivery.
    rst = 1'b0;
    push_pc(32'h0);
    push_pc(32'h4);
    smp();
    check("c0_valid", 32'(out_valid), 32'd0);
    check("c0_addr", imem_addr, 32'h0);
    nxt();
    smp();
    check("c1_valid", 32'(out_valid), 32'd1);
    check("c1_addr", imem_addr, 32'h4);
    nxt();
    smp();
    check("c2_valid", 32'(out_valid), 32'd1);
    check("c2_addr", imem_addr, 32'h8);
    nxt();

    // Decode stall at pc 0x8.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp();
      check("st_valid", 32'(out_valid), 32'd1);
      check("st_pc", out_pc, 32'h8);
      check("st_inst", out_inst, mem_word(32'h8));
      check("st_cnt", fetch_count, 32'd2);
      check("st_addr", imem_addr, 32'h8);
      nxt();
    end
    out_ready = 1'b1;
    push_pc(32'h8);
    push_pc(32'hC);
    smp();
    check("unst_valid", 32'(out_valid), 32'd1);
    nxt();
    smp();
    check("nobub_valid", 32'(out_valid), 32'd1);
    check("nobub_pc", out_pc, 32'hC);
    nxt();

    // Redirect to 0x100 squashes the word at 0x10.
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    smp();
    check("sq_valid", 32'(out_valid), 32'd0);
    check("sq_pc", out_pc, 32'h10);
    check("sq_addr", imem_addr, 32'h100);
    check("sq_cnt", fetch_count, 32'd4);
    nxt();
    redirect_valid = 1'b0;
    push_pc(32'h100);
    push_pc(32'h104);
    smp();
    check("rd_valid", 32'(out_valid), 32'd1);
    check("rd_pc", out_pc, 32'h100);
    nxt();
    smp();
    nxt();
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    smp();
    check("sq2_valid", 32'(out_valid), 32'd0);
    nxt();

    // Pause: fetch_en low during handshake at 0x20.
    redirect_valid = 1'b0;
    fetch_en = 1'b0;
    push_pc(32'h20);
    smp();
    check("p_valid", 32'(out_valid), 32'd1);
    nxt();
    for (int i = 0; i < 2; i++) begin
      smp();
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_addr", imem_addr, 32'h24);
      check("idle_cnt", fetch_count, 32'd7);
      nxt();
    end
    fetch_en = 1'b1;
    smp();
    check("bub_valid", 32'(out_valid), 32'd0);
    nxt();
    push_pc(32'h24);
    smp();
    check("res_valid", 32'(out_valid), 32'd1);
    check("res_pc", out_pc, 32'h24);
    nxt();

    // Misaligned redirect to 0x102.
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    smp();
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_addr", imem_addr, (MACRO_ON != 0) ? 32'h102 : 32'h100);
    nxt();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    push_trap(32'h102);
`else
    push_pc(32'h100);
    push_pc(32'h104);
`endif
    smp();
    check("mt_valid", 32'(out_valid), 32'd1);
    check("mt_mis", 32'(out_misalign), 32'(MACRO_ON));
    nxt();
    smp();
    check("ma_valid", 32'(out_valid), (MACRO_ON != 0) ? 32'd0 : 32'd1);
    check("ma_mis", 32'(out_misalign), 32'(MACRO_ON));
    nxt();
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    smp();
    check("mx_valid", 32'(out_valid), 32'd0);
    check("mx_addr", imem_addr, 32'h200);
    nxt();
    redirect_valid = 1'b0;
    push_pc(32'h200);
    smp();
    check("mx2_valid", 32'(out_valid), 32'd1);
    check("mx2_pc", out_pc, 32'h200);
    check("mx2_mis", 32'(out_misalign), 32'd0);
    nxt();

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    smp();
    nxt();
    redirect_valid = 1'b0;
    push_pc(32'hFFFF_FFFC);
    push_pc(32'h0);
    smp();
    check("wr_addr", imem_addr, 32'h0);
    nxt();
    smp();
    check("wr_pc", out_pc, 32'h0);
    nxt();

    // Reset during a stall at 0x30 with a simultaneous redirect.
    redirect_valid = 1'b1;
    redirect_pc = 32'h30;
    smp();
    nxt();
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      smp();
      check("s30_pc", out_pc, 32'h30);
      check("s30_cnt", fetch_count, (MACRO_ON != 0) ? 32'd12 : 32'd13);
      nxt();
    end
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h500;
    out_ready = 1'b1;
    smp();
    check("rs_valid", 32'(out_valid), 32'd0);
    check("rs_addr", imem_addr, RST_PC);
    check("rs_mis", 32'(out_misalign), 32'd0);
    nxt();
    rst = 1'b0;
    redirect_valid = 1'b0;
    smp();
    check("rr_valid", 32'(out_valid), 32'd0);
    check("rr_cnt", fetch_count, 32'd0);
    check("rr_addr", imem_addr, RST_PC);
    nxt();
    push_pc(RST_PC);
    smp();
    check("rr2_valid", 32'(out_valid), 32'd1);
    check("rr2_pc", out_pc, RST_PC);
    nxt();
    fetch_en = 1'b0;
    out_ready = 1'b0;
    smp();
    nxt();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
